key_expand: RTL and testbench
=============================

Name: key_expand

Overview:
- Iterative AES-128 key schedule. Produces one 128-bit round key per clock, with its round number, for rounds 0..10.
- Sits directly upstream of the round-key adders. Drives their shared rkey/addr bus.
- Each adder captures the key whose addr equals its ADDRESS parameter.
- One expansion per start pulse; last key is held afterwards.

Parameters:
- NROUNDS, 10, number of rounds after round 0. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to expand key; accepted only when busy=0
- key  input  128  cipher key, sampled on the accepting edge; byte 0 = key[127:120]
- busy  output  1  expansion in progress
- rkey  output  128  current round key, registered
- addr  output  4  round number of rkey (0..10), registered
- rkey_valid  output  1  rkey/addr are a freshly produced key this cycle
- done  output  1  one-cycle pulse, coincident with addr=10 valid

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset values: busy=0, rkey=0, addr=0, rkey_valid=0, done=0, round counter=0, rcon=8'h01, state=IDLE. Reset mid-expansion aborts immediately with no further valid outputs.
- States:
  - IDLE: on start=1, latch key and go to EXPAND. Otherwise stay.
  - EXPAND: produce one key per cycle. After emitting addr=10, return to IDLE.
- Timing (start sampled at edge E0):
  - After E0: rkey=key, addr=0, rkey_valid=1, busy=1.
  - After edge Ek (k=1..10): rkey=round key k, addr=k, rkey_valid=1.
  - After E10: done=1.
  - After E11: busy=0, rkey_valid=0, done=0. rkey and addr hold round-10 values until the next start.
  - Total latency: 11 valid cycles; back-to-back start is accepted at E11 earliest.
- start while busy=1 is ignored; no queuing, no effect on the current expansion.
- Round step (FIPS-197), with w0..w3 the words of the previous key (w0 = bits 127:96):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Next key computed combinationally from the rkey register and registered each cycle.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
  - Update as xtime: shift left 1; if bit 7 was set, XOR 8'h1B.
  - Reloaded to 01 on every accepted start.
- S-box: full FIPS-197 table, 4 instances. Table or composite-field implementation is implementer's choice; must be exact.
- addr never exceeds 10. Counter wrap to 11..15 is illegal; assert in simulation.
- key input may change freely after the accepting edge.

Optional Feature:
- Macro: KEY_EXPAND_REPLAY_EN
- Defined:
  - Adds an 11x128 key store, written as each round key is produced.
  - Adds input replay (1) and output replay_rdy (1). replay_rdy goes to 1 after done and to 0 on reset or a new start.
  - replay=1 while busy=0 and replay_rdy=1 re-emits stored keys in reverse order, addr=10 down to 0, for decryption. Same cycle timing as expansion: busy, rkey_valid held high for 11 cycles; done pulses with addr=0.
  - replay with replay_rdy=0 is ignored.
  - start and replay on the same edge: start wins.
- Undefined: no store, no replay ports. Behaviour is exactly as above.

Test Plan:
- FIPS-197 App. A: key=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> addr 0..10 on consecutive cycles with rkey_valid=1.
  - addr0=2b7e151628aed2a6abf7158809cf4f3c
  - addr1=a0fafe1788542cb123a339392a6c7605
  - addr10=d014f9a8c9ee2589e13f0cc8b6630ca6
  - done only with addr10.
- All-zero key -> addr1=62636363626363636263636362636363, addr10=b4ef5bcb3e92e21123e951cf6f8f188e.
  - After completion, rkey/addr hold those values with rkey_valid=0, busy=0.
- start pulsed again at addr=5 with a different key -> ignored. Sequence completes with the original key's values.
- rst asserted while addr=4 -> next cycle all outputs 0, busy=0. Following start with App. A key yields the correct full sequence (rcon restarted at 01).
- start held high continuously -> expansions back-to-back every 11 cycles with no gap cycles, each correct.
- With KEY_EXPAND_REPLAY_EN, after the App. A expansion, pulse replay:
  - addr 10 first with d014f9a8…0ca6, addr 0 last with 2b7e1516…4f3c.
  - done with addr 0.
  - replay issued before any expansion is ignored.

Source files
------------

// File: rtl/key_expand_if.sv
`default_nettype none
// ============================================================================
// key_expand_if : round-key bus between key_expand and the round-key adders.
// Optional: KEY_EXPAND_REPLAY_EN adds the replay request/ready pair.
// Rev 1.0
// ============================================================================
interface key_expand_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic [127:0] rkey;
  logic [3:0]   addr;
  logic         rkey_valid;
  logic         done;
`ifdef KEY_EXPAND_REPLAY_EN
  logic         replay;
  logic         replay_rdy;

  modport master (output start, key, replay,
                  input  busy, rkey, addr, rkey_valid, done, replay_rdy);
  modport slave  (input  start, key, replay,
                  output busy, rkey, addr, rkey_valid, done, replay_rdy);
`else
  modport master (output start, key,
                  input  busy, rkey, addr, rkey_valid, done);
  modport slave  (input  start, key,
                  output busy, rkey, addr, rkey_valid, done);
`endif
endinterface
`default_nettype wire

// File: rtl/key_expand.sv
`default_nettype none
// ============================================================================
// key_expand : iterative AES-128 key schedule, one round key per clock.
// Optional: KEY_EXPAND_REPLAY_EN adds an 11-entry key store and reverse replay.
// Rev 1.0
// ============================================================================
module key_expand #(
  parameter int NROUNDS = 10
) (
  input  wire logic   clk,
  input  wire logic   rst,
  key_expand_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_REPLAY = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         busy_q, busy_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   addr_q, addr_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] next_key;
  logic         at_last;
  logic         do_start;

  assign rot_w = {rkey_q[23:0], rkey_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_w[i*8 +: 8] = SBOX[rot_w[i*8 +: 8]];
  end

  assign t_w      = sub_w ^ {rcon_q, 24'h0};
  assign w0n      = rkey_q[127:96] ^ t_w;
  assign w1n      = rkey_q[95:64]  ^ w0n;
  assign w2n      = rkey_q[63:32]  ^ w1n;
  assign w3n      = rkey_q[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

`ifdef KEY_EXPAND_REPLAY_EN
  logic         rdy_q, rdy_d;
  logic [127:0] store_q [0:10];
  logic         do_replay;

  always_ff @(posedge clk) begin
    if (state_q == S_EXPAND) begin
      store_q[addr_q] <= rkey_q;
    end
  end

  assign at_last   = (state_q == S_EXPAND && addr_q == LAST) ||
                     (state_q == S_REPLAY && addr_q == 4'd0);
  assign do_replay = bus.replay && rdy_q && (state_q == S_IDLE) && !bus.start;
  assign bus.replay_rdy = rdy_q;
`else
  assign at_last   = (state_q == S_EXPAND && addr_q == LAST);
`endif

  // The final key cycle doubles as an accept slot so held start runs gap-free.
  assign do_start = bus.start && (state_q == S_IDLE || at_last);

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    rkey_d  = rkey_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rcon_d  = rcon_q;
`ifdef KEY_EXPAND_REPLAY_EN
    rdy_d   = rdy_q;
`endif
    case (state_q)
      S_EXPAND: begin
        if (addr_q == LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
`ifdef KEY_EXPAND_REPLAY_EN
          rdy_d   = 1'b1;
`endif
        end else begin
          rkey_d  = next_key;
          addr_d  = addr_q + 4'd1;
          valid_d = 1'b1;
          done_d  = (addr_q == LAST - 4'd1);
          rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
      end
`ifdef KEY_EXPAND_REPLAY_EN
      S_REPLAY: begin
        if (addr_q == 4'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rkey_d  = store_q[addr_q - 4'd1];
          addr_d  = addr_q - 4'd1;
          valid_d = 1'b1;
          done_d  = (addr_q == 4'd1);
        end
      end
`endif
      default: ;
    endcase

    if (do_start) begin
      state_d = S_EXPAND;
      busy_d  = 1'b1;
      rkey_d  = bus.key;
      addr_d  = 4'd0;
      valid_d = 1'b1;
      done_d  = 1'b0;
      rcon_d  = 8'h01;
`ifdef KEY_EXPAND_REPLAY_EN
      rdy_d   = 1'b0;
    end else if (do_replay) begin
      state_d = S_REPLAY;
      busy_d  = 1'b1;
      rkey_d  = store_q[LAST];
      addr_d  = LAST;
      valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      rkey_q  <= 128'h0;
      addr_q  <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rcon_q  <= 8'h01;
`ifdef KEY_EXPAND_REPLAY_EN
      rdy_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rkey_q  <= rkey_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rcon_q  <= rcon_d;
`ifdef KEY_EXPAND_REPLAY_EN
      rdy_q   <= rdy_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.rkey       = rkey_q;
  assign bus.addr       = addr_q;
  assign bus.rkey_valid = valid_q;
  assign bus.done       = done_q;

  a_addr_range: assert property (@(posedge clk) disable iff (rst) addr_q <= LAST);

endmodule
`default_nettype wire

// File: tb/tb_key_expand.sv
`default_nettype none
// tb_key_expand : directed FIPS-197 vectors plus multi-cycle corner sequences.
module tb_key_expand;
  logic clk;
  logic rst;
  key_expand_if bus ();

  key_expand #(.NROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    int           addr;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z = 128'h0;

  int tests  = 0;
  int failed = 0;

  logic [127:0] appa [0:10];
  vec_t         vecs [0:12];

  logic [127:0] got_rk [0:10];
  logic [3:0]   got_ad [0:10];
  logic         got_vl [0:10];
  logic         got_dn [0:10];
  logic         got_bz [0:10];
  logic [127:0] post_rk;
  logic [3:0]   post_ad;
  logic         post_vl, post_dn, post_bz;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Called #1 after the edge that accepted a request.
  task automatic capture(input int intrude_at, input logic [127:0] ik);
    for (int c = 0; c <= 10; c++) begin
      got_rk[c] = bus.rkey;
      got_ad[c] = bus.addr;
      got_vl[c] = bus.rkey_valid;
      got_dn[c] = bus.done;
      got_bz[c] = bus.busy;
      if (c == intrude_at) begin
        bus.start = 1'b1;
        bus.key   = ik;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    post_rk = bus.rkey;
    post_ad = bus.addr;
    post_vl = bus.rkey_valid;
    post_dn = bus.done;
    post_bz = bus.busy;
  endtask

  task automatic expand(input logic [127:0] k, input int intrude_at, input logic [127:0] ik);
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.key   = ~k;
    capture(intrude_at, ik);
  endtask

  task automatic check_frame(input string tag, input bit reverse);
    logic [3:0] a;
    int         idx;
    for (int c = 0; c <= 10; c++) begin
      idx = reverse ? 10 - c : c;
      a   = 4'(idx);
      check($sformatf("%s rkey c%0d", tag, c), got_rk[c], appa[idx]);
      check($sformatf("%s addr/valid/done/busy c%0d", tag, c),
            {got_ad[c], got_vl[c], got_dn[c], got_bz[c]},
            {a, 1'b1, (c == 10), 1'b1});
    end
    a = reverse ? 4'd0 : 4'd10;
    check($sformatf("%s post rkey", tag), post_rk, appa[reverse ? 0 : 10]);
    check($sformatf("%s post addr/valid/done/busy", tag),
          {post_ad, post_vl, post_dn, post_bz}, {a, 3'b000});
  endtask

  initial begin
    appa[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    appa[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    appa[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    appa[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    appa[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    appa[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    appa[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    appa[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    appa[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    appa[9]  = 128'hac7766f319fadc2128d12941575c006e;
    appa[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i <= 10; i++) vecs[i] = '{KEY_A, i, appa[i]};
    vecs[11] = '{KEY_Z, 1,  128'h62636363626363636263636362636363};
    vecs[12] = '{KEY_Z, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    clk       = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.key   = 128'h0;
`ifdef KEY_EXPAND_REPLAY_EN
    bus.replay = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset rkey", bus.rkey, 128'h0);
    check("reset addr/valid/done/busy",
          {bus.addr, bus.rkey_valid, bus.done, bus.busy}, 7'h0);
`ifdef KEY_EXPAND_REPLAY_EN
    check("reset replay_rdy", bus.replay_rdy, 1'b0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef KEY_EXPAND_REPLAY_EN
    bus.replay = 1'b1;
    @(posedge clk); #1;
    bus.replay = 1'b0;
    check("early replay ignored", {bus.busy, bus.rkey_valid}, 2'b00);
    @(posedge clk); #1;
    check("early replay still idle", {bus.busy, bus.rkey_valid, bus.addr}, 6'h0);
`endif

    // Table-driven round-key vectors
    for (int i = 0; i <= 12; i++) begin
      expand(vecs[i].key, -1, 128'h0);
      check($sformatf("vec%0d rkey addr%0d", i, vecs[i].addr),
            got_rk[vecs[i].addr], vecs[i].exp);
      check($sformatf("vec%0d addr/valid/done", i),
            {got_ad[vecs[i].addr], got_vl[vecs[i].addr], got_dn[vecs[i].addr]},
            {4'(vecs[i].addr), 1'b1, (vecs[i].addr == 10)});
    end

    check("zero hold rkey", post_rk, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("zero hold addr/valid/busy", {post_ad, post_vl, post_bz}, {4'd10, 2'b00});

    expand(KEY_A, -1, 128'h0);
    check_frame("appA", 1'b0);

    expand(KEY_A, 5, KEY_Z);
    check_frame("start_ignored", 1'b0);

    // Reset while addr=4, then a clean restart
    bus.key   = KEY_A;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset addr", bus.addr, 4'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid reset rkey", bus.rkey, 128'h0);
    check("mid reset addr/valid/done/busy",
          {bus.addr, bus.rkey_valid, bus.done, bus.busy}, 7'h0);
    @(posedge clk); #1;
    check("after reset idle", {bus.rkey_valid, bus.busy}, 2'b00);
    expand(KEY_A, -1, 128'h0);
    check_frame("after_rst", 1'b0);

`ifdef KEY_EXPAND_REPLAY_EN
    check("replay_rdy after done", bus.replay_rdy, 1'b1);
    bus.replay = 1'b1;
    @(posedge clk); #1;
    bus.replay = 1'b0;
    capture(-1, 128'h0);
    check_frame("replay", 1'b1);
`endif

    // Start held high: two gap-free expansions
    bus.key   = KEY_A;
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(posedge clk); #1;
      check($sformatf("held rkey cyc%0d", cyc), bus.rkey, appa[cyc % 11]);
      check($sformatf("held addr/valid/done/busy cyc%0d", cyc),
            {bus.addr, bus.rkey_valid, bus.done, bus.busy},
            {4'(cyc % 11), 1'b1, (cyc % 11 == 10), 1'b1});
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("held end idle", {bus.addr, bus.rkey_valid, bus.done, bus.busy}, {4'd10, 3'b000});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
